// File: rtl/dpram_reader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dpram_reader_pkg
// Purpose  : Shared definitions for the dpram read-side streaming controller:
//            the clog2 helper (also used by dpram), the controller state
//            encoding and the read credit limit.
// Revision : 1.0 - initial release
// ============================================================================
package dpram_reader_pkg;

    // Ceiling log2 for sizing address buses from a power-of-two depth.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

    typedef enum logic [1:0] {
        RD_IDLE  = 2'd0,
        RD_RUN   = 2'd1,
        RD_DRAIN = 2'd2
    } rd_state_t;

    // Words issued to the dpram but not yet accepted downstream.
    localparam int RD_CREDITS = 4;

endpackage
`default_nettype wire

// File: rtl/dpram_reader_rd_skid_fifo.sv
`default_nettype none
// ============================================================================
// Module   : rd_skid_fifo
// Purpose  : 4-entry synchronous FIFO holding captured read words and their
//            last tags. Simultaneous push and pop are both honoured.
// Ports    : clk, rst        - clock, synchronous active-high reset
//            push, din       - write request and data
//            pop             - read request (advances head)
//            dout            - head entry (all zero after reset)
//            full, empty     - occupancy flags
// Revision : 1.0 - initial release
// ============================================================================
module rd_skid_fifo #(
    parameter int DW = 33
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] din,
    input  logic          pop,
    output logic [DW-1:0] dout,
    output logic          full,
    output logic          empty
);

    localparam int c_ENTRIES = 4;

    logic [DW-1:0] r_mem [c_ENTRIES];
    logic [1:0]    r_wr_ptr;
    logic [1:0]    r_rd_ptr;
    logic [2:0]    r_count;
    logic          w_wr;
    logic          w_rd;

    assign w_rd = pop & ~empty;
    // A write while full is accepted only when the head leaves in the same cycle.
    assign w_wr = push & (~full | w_rd);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= 2'd0;
            r_rd_ptr <= 2'd0;
            r_count  <= 3'd0;
            // Cleared so the head reads as zero after reset.
            for (int i = 0; i < c_ENTRIES; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_wr) begin
                r_mem[r_wr_ptr] <= din;
                r_wr_ptr        <= r_wr_ptr + 2'd1;
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + 2'd1;
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + 3'd1;
                2'b01:   r_count <= r_count - 3'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign dout  = r_mem[r_rd_ptr];
    assign full  = (r_count == 3'd4);
    assign empty = (r_count == 3'd0);

endmodule
`default_nettype wire

// File: rtl/dpram_reader.sv
`default_nettype none
// ============================================================================
// Module   : dpram_reader
// Purpose  : Read-side streaming controller for a dpram. Takes a command
//            (start address, word count), issues reads on ren/addrb, captures
//            the registered doutb one cycle later and streams the words out on
//            a valid/ready interface with m_last on the final word. Reads are
//            credit-limited so the 4-entry buffer can never overflow.
// Ports    : clk, rst                     - clock, sync active-high reset
//            cmd_valid/ready/addr/len     - command handshake (len 0..DEPTH)
//            ren, addrb, doutb            - dpram read port
//            m_valid/ready/data/last      - output stream
//            busy                         - controller not idle
// Revision : 1.0 - initial release
// ============================================================================
module dpram_reader
    import dpram_reader_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 1024,
    localparam int AW    = clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [AW-1:0]    cmd_addr,
    input  logic [AW:0]      cmd_len,
    output logic             ren,
    output logic [AW-1:0]    addrb,
    input  logic [WIDTH-1:0] doutb,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             m_last,
    output logic             busy
);

    localparam logic [2:0]    c_CREDIT_MAX = 3'(RD_CREDITS);
    localparam logic [AW:0]   c_LEN_ONE    = (AW+1)'(1);
    localparam logic [AW-1:0] c_ADDR_ONE   = AW'(1);

    rd_state_t     r_state;
    logic [AW-1:0] r_rd_addr;
    logic [AW:0]   r_remaining;
    logic [2:0]    r_credit;
    logic          r_pend;
    logic          r_pend_last;

    logic          w_issue;
    logic          w_pop;
    logic          w_push;
    logic          w_full;
    logic          w_empty;
    logic [WIDTH:0] w_head;

    assign w_pop = m_valid & m_ready;

    // At the credit limit a read may still issue when a word leaves in the
    // same cycle, which keeps full throughput under intermittent stalls.
    assign w_issue = (r_state == RD_RUN) && (r_remaining != '0) &&
                     ((r_credit < c_CREDIT_MAX) || w_pop);

    assign ren   = w_issue;
    assign addrb = r_rd_addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= RD_IDLE;
            r_rd_addr   <= '0;
            r_remaining <= '0;
            r_credit    <= 3'd0;
            r_pend      <= 1'b0;
            r_pend_last <= 1'b0;
        end else begin
            // doutb is valid the cycle after ren; r_pend marks that cycle.
            r_pend      <= w_issue;
            r_pend_last <= w_issue && (r_remaining == c_LEN_ONE);

            if (w_issue) begin
                r_rd_addr   <= r_rd_addr + c_ADDR_ONE;
                r_remaining <= r_remaining - c_LEN_ONE;
            end

            case ({w_issue, w_pop})
                2'b10:   r_credit <= r_credit + 3'd1;
                2'b01:   r_credit <= r_credit - 3'd1;
                default: r_credit <= r_credit;
            endcase

            case (r_state)
                RD_IDLE: begin
                    if (cmd_valid) begin
                        r_rd_addr   <= cmd_addr;
                        r_remaining <= cmd_len;
                        // A zero-length command is consumed without leaving IDLE.
                        if (cmd_len != '0) begin
                            r_state <= RD_RUN;
                        end
                    end
                end
                RD_RUN: begin
                    if (w_issue && (r_remaining == c_LEN_ONE)) begin
                        r_state <= RD_DRAIN;
                    end
                end
                RD_DRAIN: begin
                    if (w_pop && m_last) begin
                        r_state <= RD_IDLE;
                    end
                end
                default: r_state <= RD_IDLE;
            endcase
        end
    end

    // Credit accounting guarantees room; the full term only matters when a
    // pop frees the slot in the same cycle.
    assign w_push = r_pend & (~w_full | w_pop);

    rd_skid_fifo #(
        .DW (WIDTH + 1)
    ) u_buf (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .din   ({r_pend_last, doutb}),
        .pop   (w_pop),
        .dout  (w_head),
        .full  (w_full),
        .empty (w_empty)
    );

    assign m_valid   = ~w_empty;
    assign m_data    = w_head[WIDTH-1:0];
    assign m_last    = w_head[WIDTH];
    assign cmd_ready = (r_state == RD_IDLE);
    assign busy      = ~cmd_ready;

endmodule
`default_nettype wire

// File: doc/dpram_reader.md
# dpram_reader

Read-side streaming controller for the `dpram` block. It accepts a command (start address, word count) and drives the dpram read port (`ren`/`addrb`), capturing the registered `doutb` one cycle after each read. Captured words leave on a valid/ready stream with `m_last` marking the final word. Backpressure is absorbed by credit-limited issue into a 4-entry buffer, so no word is lost or duplicated. It sits between a dpram instance and any downstream consumer, such as a DMA or instruction/data fetch path.

## Interface
- `WIDTH`, 32, data width; must match the attached dpram.
- `DEPTH`, 1024, dpram depth; power of two. `AW = clog2(DEPTH)`.
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  reset; synchronous and active-high.
- `cmd_valid`  in  1  command request.
- `cmd_ready`  out  1  high only in IDLE.
- `cmd_addr`  in  AW  start address.
- `cmd_len`  in  AW+1  word count, 0..DEPTH.
- `ren`  out  1  dpram read enable.
- `addrb`  out  AW  dpram read address.
- `doutb`  in  WIDTH  dpram registered read data; valid the cycle after `ren`.
- `m_valid`  out  1  stream data valid.
- `m_ready`  in  1  consumer accept.
- `m_data`  out  WIDTH  stream data.
- `m_last`  out  1  high with the final word of a command.
- `busy`  out  1  high while not IDLE (`busy = ~cmd_ready`).

## Operation
- **States**
  - **IDLE**: `cmd_ready=1`. On `cmd_valid`, latch the address into `rd_addr` and the count into `remaining`. Go to RUN, or stay in IDLE when `cmd_len==0`: a zero-length command is consumed and produces no words.
  - **RUN**: issue reads.
  - **DRAIN**: entered after the final read issues. Returns to IDLE on the `m_last` handshake.
- **Issue rule** (RUN only)
  - `ren=1` when `remaining>0` and `credit<4`, or when `credit==4` and a stream pop occurs in the same cycle.
  - On issue: `addrb=rd_addr`, `rd_addr` increments modulo 2^AW, `remaining` decrements.
  - `ren` never asserts outside RUN.
- **Credit counter**
  - Counts words issued but not yet popped, range 0..4.
  - +1 on issue, −1 on pop (`m_valid & m_ready`). Simultaneous issue and pop leave it unchanged.
  - Because `credit ≤ 4`, the buffer can never overflow.
- **Capture**
  - A 1-bit `rd_pend` register is set on issue, with a `last` tag equal to (`remaining==1`).
  - In the following cycle, `doutb` and the tag are written into the buffer.
- **Buffer**
  - 4-entry FIFO of {data, last}. `m_valid = ~empty`; `m_data`/`m_last` come from the head entry.
  - Push and pop in the same cycle are both honoured.
- **Stream rules**
  - While `m_valid & ~m_ready`, `m_data` and `m_last` hold stable.
  - `m_valid` never drops without a handshake.
- **Commands**: `cmd_valid` outside IDLE is ignored, with no queuing.
- **Reset** (including mid-operation)
  - Go to IDLE; `credit`, `remaining`, `rd_pend` and the buffer are cleared.
  - Any in-flight `doutb` is discarded.
  - The first command after reset sees no stale words.

## Timing
- Reset values:
  - `cmd_ready=1`, `busy=0`, `ren=0`.
  - `addrb=0`, `m_valid=0`, `m_data=0`, `m_last=0`.
- With the command handshake in cycle 0:
  - First `ren` in cycle 1.
  - First `m_valid` in cycle 3.
- With `m_ready` held high, throughput is 1 word/cycle. N words end with `m_last` in cycle N+2, and `cmd_ready` rises in cycle N+3.
- Under backpressure, at most 4 words are outstanding. Issue resumes in the same cycle as a pop.

## Structure
- Shared package/header:
  - `clog2` function (shared with dpram).
  - State encodings `RD_IDLE=2'd0`, `RD_RUN=2'd1`, `RD_DRAIN=2'd2`.
  - Credit limit constant `RD_CREDITS=4`.
- Sub-module `rd_skid_fifo`: 4-entry, width WIDTH+1, synchronous reset, push/pop/full/empty. It is instantiated once.
- The dpram is instantiated outside this block, by its parent.

## Test plan
- **Reset**: assert `rst` 2 cycles → all outputs at their reset values; `cmd_ready=1`.
- **Burst**: memory preloaded with mem[i]=i; cmd addr=5 len=4 with `m_ready=1` → `ren` cycles 1–4 with `addrb` 5,6,7,8; `m_data` 5,6,7,8 in cycles 3–6; `m_last` in cycle 6; `cmd_ready` high in cycle 7.
- **Wrap**: DEPTH=16, addr=14, len=4 → `addrb` 14,15,0,1; data matches those addresses.
- **Backpressure**: len=16 with `m_ready` low for cycles 4–13 → `credit` peaks at 4; `ren` is low while stalled; `m_data` is stable; all 16 words arrive in order exactly once.
- **Zero-length and busy commands**: len=0 → no `ren`, no `m_valid`, `cmd_ready` high next cycle. A second command issued while `busy` is ignored.
- **Reset mid-burst**: `rst` during word 3 of 8, then cmd addr=0 len=2 → only mem[0] and mem[1] are emitted, with `m_last` on the second word.
